nios_basic_nios2_gen2_0_cpu_mult_seq: RTL and testbench

NIOS_BASIC_NIOS2_GEN2_0_CPU_MULT_SEQ -- requirements
Module: nios_basic_nios2_gen2_0_cpu_mult_seq

---
 rtl/nios_basic_nios2_gen2_0_cpu_mult_pkg.sv | 24 ++
 rtl/nios_basic_nios2_gen2_0_cpu_mult_seq.sv | 130 +++++++++++++
 tb/tb_nios_basic_nios2_gen2_0_cpu_mult_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/nios_basic_nios2_gen2_0_cpu_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios_basic_nios2_gen2_0_cpu_mult_pkg
// Purpose  : Shared definitions for the sequential multiplier: operation
//            encodings and the sequencer state enumeration.
// Revision : 1.0 - initial release
// ============================================================================
package nios_basic_nios2_gen2_0_cpu_mult_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;  // low word of product
  localparam logic [1:0] OP_MULXUU = 2'b01;  // high word, unsigned x unsigned
  localparam logic [1:0] OP_MULXSU = 2'b10;  // high word, signed x unsigned
  localparam logic [1:0] OP_MULXSS = 2'b11;  // high word, signed x signed

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE1 = 3'd1,
    ST_CAP1   = 3'd2,
    ST_CAP2   = 3'd3,
    ST_DONE   = 3'd4
  } mult_state_t;

endpackage : nios_basic_nios2_gen2_0_cpu_mult_pkg
`default_nettype wire

// File: rtl/nios_basic_nios2_gen2_0_cpu_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : nios_basic_nios2_gen2_0_cpu_mult_seq
// Purpose  : Sequencer for a 32x32 multiply built on an external 16x16
//            partial-product cell. Issues lo/cross products, then (for the
//            MULX* high-word forms) the hi*hi product, and combines them.
// Ports    : clk, reset (async, active-high)
//            start/op/src1/src2 - request; accepted when ready=1
//            flush              - abort any operation in flight
//            ready/done/result  - status and held product word
//            cell_src1/cell_src2/cell_en - operands + enable to the cell
//            cell_p1/p2/p3      - cell products, valid one edge after cell_en
// Revision : 1.0 - initial release
// ============================================================================
module nios_basic_nios2_gen2_0_cpu_mult_seq
  import nios_basic_nios2_gen2_0_cpu_mult_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  mult_state_t r_state, w_next;
  logic [1:0]  r_op;
  logic [31:0] r_src1, r_src2;
  logic [31:0] r_acc_hi;   // upper word of the lo/cross accumulation
  logic [31:0] r_result;

  logic [33:0] w_mid;
  logic [63:0] w_acc64;
  logic [31:0] w_uhi, w_corr1, w_corr2, w_hi_word;

  // Cross products summed at 34 bits so their carries reach acc64[49:48].
  assign w_mid   = {2'b00, cell_p2} + {2'b00, cell_p3};
  assign w_acc64 = {32'h0, cell_p1} + ({30'h0, w_mid} << 16);

  // Unsigned high word, then signed corrections: a negative operand's
  // two's-complement weight subtracts the other operand from the high word.
  assign w_uhi   = r_acc_hi + cell_p1;
  assign w_corr1 = r_src1[31] ? r_src2 : 32'h0;
  assign w_corr2 = r_src2[31] ? r_src1 : 32'h0;

  always_comb begin
    w_hi_word = w_uhi;
    case (r_op)
      OP_MULXSU: w_hi_word = w_uhi - w_corr1;
      OP_MULXSS: w_hi_word = w_uhi - w_corr1 - w_corr2;
      default:   w_hi_word = w_uhi;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    ready     = 1'b0;
    done      = 1'b0;
    cell_en   = 1'b0;
    cell_src1 = 32'h0;
    cell_src2 = 32'h0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) w_next = ST_ISSUE1;
      end
      ST_ISSUE1: begin
        cell_en   = 1'b1;
        cell_src1 = r_src1;
        cell_src2 = r_src2;
        w_next    = ST_CAP1;
      end
      ST_CAP1: begin
        if (r_op == OP_MUL) begin
          w_next = ST_DONE;
        end else begin
          // Reuse the cell's lo*lo lane for hi*hi.
          cell_en   = 1'b1;
          cell_src1 = {16'h0, r_src1[31:16]};
          cell_src2 = {16'h0, r_src2[31:16]};
          w_next    = ST_CAP2;
        end
      end
      ST_CAP2: w_next = ST_DONE;
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (flush) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_MUL;
      r_src1   <= 32'h0;
      r_src2   <= 32'h0;
      r_acc_hi <= 32'h0;
      r_result <= 32'h0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && start && !flush) begin
        r_op   <= op;
        r_src1 <= src1;
        r_src2 <= src2;
      end
      if (r_state == ST_CAP1 && !flush) begin
        r_acc_hi <= w_acc64[63:32];
        if (r_op == OP_MUL) r_result <= w_acc64[31:0];
      end
      if (r_state == ST_CAP2 && !flush) r_result <= w_hi_word;
    end
  end

  assign result = r_result;

endmodule : nios_basic_nios2_gen2_0_cpu_mult_seq
`default_nettype wire

// File: tb/tb_nios_basic_nios2_gen2_0_cpu_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_basic_nios2_gen2_0_cpu_mult_seq
// Purpose  : Directed bench for the sequential multiplier, with a behavioural
//            16x16 partial-product cell wired to the cell_* ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios_basic_nios2_gen2_0_cpu_mult_seq;
  import nios_basic_nios2_gen2_0_cpu_mult_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src1 = 32'h0, src2 = 32'h0;
  logic        flush = 1'b0;
  logic        ready, done, cell_en;
  logic [31:0] result, cell_src1, cell_src2;
  logic [31:0] cell_p1 = 32'h0, cell_p2 = 32'h0, cell_p3 = 32'h0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nios_basic_nios2_gen2_0_cpu_mult_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2),
    .flush(flush), .ready(ready), .done(done), .result(result),
    .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_en(cell_en),
    .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3)
  );

  // Partial-product cell: registered products, captured when cell_en=1.
  always @(posedge clk) begin
    if (cell_en) begin
      cell_p1 <= 32'(cell_src1[15:0]) * 32'(cell_src2[15:0]);
      cell_p2 <= 32'(cell_src1[15:0]) * 32'(cell_src2[31:16]);
      cell_p3 <= 32'(cell_src1[31:16]) * 32'(cell_src2[15:0]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one operation and watches 8 cycles: latency counts edges from the
  // accepting edge (inclusive) until done is seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output logic [31:0] res, output int lat,
                        output int ens, output int ndone);
    @(negedge clk);
    op = o; src1 = a; src2 = b; start = 1'b1;
    lat = 0; ens = 0; ndone = 0; res = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (cell_en) ens++;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          lat = c;
          res = result;
        end
        if (hold) start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] res;
    int lat, ens, ndone, cnt;

    vecs[0]  = '{OP_MUL,    32'h00012345, 32'h00010000, 32'h23450000};
    vecs[1]  = '{OP_MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2]  = '{OP_MULXSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[3]  = '{OP_MULXSS, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[4]  = '{OP_MULXSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[5]  = '{OP_MUL,    32'h00000003, 32'h00000005, 32'h0000000F};
    vecs[6]  = '{OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[7]  = '{OP_MULXUU, 32'h80000000, 32'h00000002, 32'h00000001};
    vecs[8]  = '{OP_MULXSU, 32'h80000000, 32'h00000002, 32'hFFFFFFFF};
    vecs[9]  = '{OP_MUL,    32'h80000000, 32'h80000000, 32'h00000000};
    vecs[10] = '{OP_MULXSS, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
    vecs[11] = '{OP_MUL,    32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001};
    vecs[12] = '{OP_MULXUU, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF};
    vecs[13] = '{OP_MULXSS, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};

    // Reset state while reset is held.
    #1;
    chk("reset_ready", 32'(ready), 32'h1);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_result", result, 32'h0);
    chk("reset_cell_en", 32'(cell_en), 32'h0);
    chk("reset_cell_src1", cell_src1, 32'h0);
    chk("reset_cell_src2", cell_src2, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, res, lat, ens, ndone);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), (vecs[i].op == OP_MUL) ? 32'd3 : 32'd4);
      chk($sformatf("vec%0d_cell_en_cycles", i), 32'(ens), (vecs[i].op == OP_MUL) ? 32'd1 : 32'd2);
      chk($sformatf("vec%0d_done_count", i), 32'(ndone), 32'd1);
      chk($sformatf("vec%0d_result_held", i), result, vecs[i].exp);
    end

    // Start held high through the operation: a single done only.
    run_op(OP_MULXUU, 32'h00010000, 32'h00010000, 1'b1, res, lat, ens, ndone);
    chk("hold_result", res, 32'h00000001);
    chk("hold_done_count", 32'(ndone), 32'd1);
    chk("hold_latency", 32'(lat), 32'd4);
    // A second op is accepted once back in IDLE.
    run_op(OP_MUL, 32'h00000007, 32'h00000006, 1'b0, res, lat, ens, ndone);
    chk("second_op_result", res, 32'h0000002A);

    // Flush in CAP1 of a MULXUU.
    @(negedge clk);
    op = OP_MULXUU; src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk); start = 1'b0;          // ISSUE1
    @(negedge clk); flush = 1'b1;          // CAP1
    chk("flush_in_cap1_busy", 32'(ready), 32'h0);
    @(negedge clk); flush = 1'b0;
    chk("flush_ready", 32'(ready), 32'h1);
    chk("flush_done", 32'(done), 32'h0);
    chk("flush_result_held", result, 32'h0000002A);
    cnt = 0;
    repeat (5) begin @(negedge clk); if (done) cnt++; end
    chk("flush_no_done", 32'(cnt), 32'd0);
    chk("flush_result_after", result, 32'h0000002A);

    // Flush together with start in IDLE: not accepted.
    @(negedge clk); start = 1'b1; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    chk("flush_start_ready", 32'(ready), 32'h1);
    chk("flush_start_cell_en", 32'(cell_en), 32'h0);
    cnt = 0;
    repeat (5) begin @(negedge clk); if (done) cnt++; end
    chk("flush_start_no_done", 32'(cnt), 32'd0);

    // Reset asserted in CAP2.
    @(negedge clk);
    op = OP_MULXUU; src1 = 32'h12345678; src2 = 32'h9ABCDEF0; start = 1'b1;
    @(negedge clk); start = 1'b0;          // ISSUE1
    @(negedge clk);                        // CAP1
    @(negedge clk);                        // CAP2
    chk("cap2_busy", 32'(ready), 32'h0);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_ready", 32'(ready), 32'h1);
    chk("async_reset_done", 32'(done), 32'h0);
    chk("async_reset_result", result, 32'h0);
    chk("async_reset_cell_en", 32'(cell_en), 32'h0);
    chk("async_reset_cell_src", cell_src1 | cell_src2, 32'h0);
    @(negedge clk); reset = 1'b0;
    cnt = 0;
    repeat (5) begin @(negedge clk); if (done) cnt++; end
    chk("reset_no_done", 32'(cnt), 32'd0);
    run_op(OP_MUL, 32'h00000003, 32'h00000005, 1'b0, res, lat, ens, ndone);
    chk("post_reset_mul", res, 32'h0000000F);
    chk("post_reset_latency", 32'(lat), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_nios_basic_nios2_gen2_0_cpu_mult_seq
`default_nettype wire
